// File: rtl/if_id_skid_if.sv
// Fetch/decode handshake bundle for the IF->ID skid register.
// The slave modport is the buffer's view; the master modport drives it.
interface if_id_skid_if #(
    parameter int PC_WIDTH    = 12,
    parameter int INSTR_WIDTH = 12
);
    logic                   in_valid;
    logic                   in_ready;
    logic [PC_WIDTH-1:0]    in_pc;
    logic [INSTR_WIDTH-1:0] in_instr;
    logic                   out_valid;
    logic                   out_ready;
    logic [PC_WIDTH-1:0]    out_pc;
    logic [INSTR_WIDTH-1:0] out_instr;

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/if_id_skid.sv
// Elastic IF->ID register: main entry plus one skid entry, registered in_ready,
// NOP bubbles when empty or flushed, and a saturating backpressure counter.
module if_id_skid #(
    parameter int                     PC_WIDTH    = 12,
    parameter int                     INSTR_WIDTH = 12,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0,
    parameter int                     CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    if_id_skid_if.slave          pipe,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] stall_cnt
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [PC_WIDTH-1:0]    main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic [INSTR_WIDTH-1:0] main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
    logic                   in_ready_q, in_ready_d;
    logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
    logic                   out_valid, acc, cons;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign out_valid = (state_q != EMPTY);
    assign acc       = pipe.in_valid & in_ready_q & ~flush;
    assign cons      = out_valid & pipe.out_ready;

    // Main entry is forced to bubble whenever it empties, so outputs stay register-driven.
    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (flush) begin
            state_d      = EMPTY;
            main_pc_d    = '0;
            main_instr_d = NOP_INSTR;
            skid_pc_d    = '0;
            skid_instr_d = NOP_INSTR;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d      = ONE;
                        main_pc_d    = pipe.in_pc;
                        main_instr_d = pipe.in_instr;
                    end
                end
                ONE: begin
                    if (acc && cons) begin
                        main_pc_d    = pipe.in_pc;
                        main_instr_d = pipe.in_instr;
                    end else if (acc) begin
                        state_d      = TWO;
                        skid_pc_d    = pipe.in_pc;
                        skid_instr_d = pipe.in_instr;
                    end else if (cons) begin
                        state_d      = EMPTY;
                        main_pc_d    = '0;
                        main_instr_d = NOP_INSTR;
                    end
                end
                TWO: begin
                    if (cons) begin
                        state_d      = ONE;
                        main_pc_d    = skid_pc_q;
                        main_instr_d = skid_instr_q;
                        skid_pc_d    = '0;
                        skid_instr_d = NOP_INSTR;
                    end
                end
                default: begin
                    state_d      = EMPTY;
                    main_pc_d    = '0;
                    main_instr_d = NOP_INSTR;
                end
            endcase
        end
    end

    assign in_ready_d  = (state_d != TWO);
    assign stall_cnt_d = (out_valid && !pipe.out_ready && !flush) ? sat_inc(stall_cnt_q)
                                                                  : stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            in_ready_q   <= 1'b1;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            in_ready_q   <= in_ready_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign pipe.in_ready  = in_ready_q;
    assign pipe.out_valid = out_valid;
    assign pipe.out_pc    = main_pc_q;
    assign pipe.out_instr = main_instr_q;
    assign occupancy      = state_q;
    assign stall_cnt      = stall_cnt_q;
endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_if_id_skid;
    localparam int               PW   = 12;
    localparam int               IW   = 12;
    localparam int               CW   = 8;
    localparam logic [IW-1:0]    NOP  = 12'hA5A;
    localparam int unsigned      CMAX = (1 << CW) - 1;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    if_id_skid_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

    if_id_skid #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .NOP_INSTR(NOP), .CNT_WIDTH(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .pipe     (bus),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] pc;
        logic [IW-1:0] instr;
    } beat_t;

    beat_t       mq[$];
    int unsigned mcnt = 0;
    int          checks = 0;
    int          failures = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: a FIFO of at most two beats, updated per the handshake rules.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            mcnt = 0;
        end else begin
            bit    acc, cons;
            beat_t b;
            acc  = bus.in_valid && (mq.size() < 2) && !flush;
            cons = (mq.size() > 0) && bus.out_ready;
            if ((mq.size() > 0) && !bus.out_ready && !flush && mcnt < CMAX) mcnt++;
            if (flush) begin
                mq.delete();
            end else begin
                if (cons) void'(mq.pop_front());
                if (acc) begin
                    b.pc    = bus.in_pc;
                    b.instr = bus.in_instr;
                    mq.push_back(b);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            bit v;
            v = (mq.size() > 0);
            chk("m_out_valid", 32'(bus.out_valid), 32'(v));
            chk("m_out_pc",    32'(bus.out_pc),    v ? 32'(mq[0].pc)    : 32'd0);
            chk("m_out_instr", 32'(bus.out_instr), v ? 32'(mq[0].instr) : 32'(NOP));
            chk("m_occupancy", 32'(occupancy),     32'(mq.size()));
            chk("m_in_ready",  32'(bus.in_ready),  32'(mq.size() < 2));
            chk("m_stall_cnt", 32'(stall_cnt),     32'(mcnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [PW-1:0] pc, input logic [IW-1:0] ins,
                         input bit rdy);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        bus.out_ready = rdy;
    endtask

    initial begin
        drive(0, '0, '0, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_instr", 32'(bus.out_instr), 32'(NOP));
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_occupancy", 32'(occupancy),     32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt),     32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Latency-1 first beat
        drive(1, 12'h004, 12'h123, 1);
        tick();
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_out_pc",    32'(bus.out_pc),    32'h004);
        chk("t1_out_instr", 32'(bus.out_instr), 32'h123);
        chk("t1_occupancy", 32'(occupancy),     32'd1);

        // Full-rate streaming
        for (int i = 0; i < 4; i++) begin
            drive(1, 12'(4 * i), 12'(12'h200 + i), 1);
            tick();
            chk("t2_out_pc",   32'(bus.out_pc),   32'(4 * i));
            chk("t2_in_ready", 32'(bus.in_ready), 32'd1);
        end
        chk("t2_stall_cnt", 32'(stall_cnt), 32'd0);
        drive(0, '0, '0, 1);
        tick();

        // Backpressure fills the skid entry, then drains in order
        drive(1, 12'h010, 12'h310, 0);
        tick();
        drive(1, 12'h014, 12'h314, 0);
        tick();
        chk("t3_occupancy", 32'(occupancy),     32'd2);
        chk("t3_in_ready",  32'(bus.in_ready),  32'd0);
        drive(1, 12'h018, 12'h318, 0);
        tick();
        tick();
        chk("t3_hold_pc", 32'(bus.out_pc), 32'h010);
        drive(1, 12'h018, 12'h318, 1);
        tick();
        chk("t3_drain1_pc", 32'(bus.out_pc), 32'h014);
        tick();
        chk("t3_drain2_pc",    32'(bus.out_pc),    32'h018);
        chk("t3_drain2_instr", 32'(bus.out_instr), 32'h318);
        drive(0, '0, '0, 1);
        tick();
        chk("t3_empty", 32'(bus.out_valid), 32'd0);

        // Flush while full drops the offered beat
        drive(1, 12'h030, 12'h330, 0);
        tick();
        drive(1, 12'h034, 12'h334, 0);
        tick();
        flush = 1'b1;
        drive(1, 12'h020, 12'h320, 0);
        tick();
        flush = 1'b0;
        chk("t4_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_out_instr", 32'(bus.out_instr), 32'(NOP));
        chk("t4_out_pc",    32'(bus.out_pc),    32'd0);
        chk("t4_occupancy", 32'(occupancy),     32'd0);
        chk("t4_in_ready",  32'(bus.in_ready),  32'd1);
        drive(0, '0, '0, 1);
        tick();
        chk("t4_no_020", 32'(bus.out_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            flush = ($urandom_range(0, 19) == 0);
            drive(($urandom_range(0, 9) < 7), 12'($urandom), 12'($urandom),
                  ($urandom_range(0, 9) < 6));
            tick();
        end
        flush = 1'b0;

        // Stall counter saturation
        drive(1, 12'h0F0, 12'h3F0, 0);
        tick();
        drive(0, '0, '0, 0);
        repeat (300) tick();
        chk("t5_stall_sat", 32'(stall_cnt), 32'(CMAX));
        repeat (5) tick();
        chk("t5_stall_hold", 32'(stall_cnt), 32'(CMAX));

        // Asynchronous reset while full
        drive(1, 12'h0E0, 12'h3E0, 0);
        tick();
        chk("t6_occupancy", 32'(occupancy), 32'd2);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_out_pc",    32'(bus.out_pc),    32'd0);
        chk("t6_out_instr", 32'(bus.out_instr), 32'(NOP));
        chk("t6_occupancy", 32'(occupancy),     32'd0);
        chk("t6_in_ready",  32'(bus.in_ready),  32'd1);
        chk("t6_stall_cnt", 32'(stall_cnt),     32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 12'h040, 12'h0AB, 1);
        tick();
        chk("t6_post_valid", 32'(bus.out_valid), 32'd1);
        chk("t6_post_pc",    32'(bus.out_pc),    32'h040);
        chk("t6_post_instr", 32'(bus.out_instr), 32'h0AB);
        drive(0, '0, '0, 1);
        repeat (3) tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
